// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx - 8N1 asynchronous serial receiver
//
// Frame format: 1 start bit (0), 8 data bits LSB first, no parity, 1 stop
// bit (1). Bit timing comes from a clk-cycle counter. The counter counts
// CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE cycles per bit. The start bit is
// re-checked at its midpoint, which is HALF_BIT cycles after the falling edge.
// Each later sample is taken one full bit period after the previous one, so
// every sample lands near the middle of its bit.
//
// Parameters:
//   BAUD_RATE   serial bit rate in bits/s (default 9600)
//   CLOCK_FREQ  clk frequency in Hz      (default 38400000)
//   CLKS_PER_BIT must come out >= 4.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (release synchronous to clk)
//   rx         in   serial line, asynchronous to clk, idle high
//   data[7:0]  out  last correctly framed byte, held between frames
//   valid      out  one-cycle pulse when data is updated
//   frame_err  out  one-cycle pulse on a stop-bit sample of 0
//                   (present only when UART_RX_FRAME_ERR_EN is defined)
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
//   Defined:   adds frame_err.
//   Undefined: the frame_err port is absent, and frames with a bad stop bit
//              are dropped without any indication.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 38400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  logic start_edge;
  logic half_done;
  logic bit_done;

  // A falling edge of the synchronised line starts a frame. A line held low
  // (for example a break) never produces another edge, so it cannot retrigger.
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign half_done  = (cnt_q == HALF_LAST);
  assign bit_done   = (cnt_q == BIT_LAST);

  // ---------------------------------------------------------------------------
  // Input synchroniser and previous-sample register. All of these reset to 1,
  // which is the idle line level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit check. If the line is already high again, the low
        // pulse was a glitch and the receiver goes back to IDLE.
        if (half_done) begin
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    // The counter restarts on every state change. Within a state it counts
    // freely, except in IDLE where it stays at 0.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_START: begin
        bit_idx_d = '0;
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          cnt_d              = '0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_d = 1'b1;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx
//
// The bench uses a scaled bit rate, CLKS_PER_BIT = 16, so a frame takes 160
// cycles. The reference model works at the level of whole frames. When the
// bench sends a frame with a good stop bit that is not aborted, it queues
// the byte and its start-edge cycle. Every valid pulse must match the head
// of that queue, both in data and in latency: HALF_BIT + 9*CLKS_PER_BIT,
// +/-3 cycles. The bench also keeps a model of the held data value.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BAUD    = 1;
  localparam int CLKF    = 16;
  localparam int CPB     = CLKF / BAUD;
  localparam int HALF    = CPB / 2;
  localparam int LAT_NOM = HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  uart_rx #(
    .BAUD_RATE (BAUD),
    .CLOCK_FREQ(CLKF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .valid(valid)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] data_model = 8'h00;
  int         n_valid    = 0;
  int         n_good     = 0;
  int         n_checks   = 0;
  int         n_errors   = 0;
`ifdef UART_RX_FRAME_ERR_EN
  int         fe_pending = 0;
  int         n_fe_seen  = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sends one frame, starting at the current negedge. If abort_bit is 0..7,
  // the task pulses reset in the middle of that data bit and then returns
  // with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
    exp_t e;
    rx = 1'b0;
    if (abort_bit < 0) begin
      if (stop) begin
        e.b = b;
        e.t = cyc;
        expq.push_back(e);
        n_good++;
      end else begin
`ifdef UART_RX_FRAME_ERR_EN
        fe_pending++;
`endif
      end
    end
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        repeat (HALF) @(negedge clk);
        rst        = 1'b0;
        rx         = 1'b1;
        data_model = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Output monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    int   lat;
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        check("valid_2cyc", 32'(valid_prev), 32'd0);
        if (expq.size() == 0) begin
          check("unexp_valid", 32'(valid), 32'd0);
        end else begin
          e   = expq.pop_front();
          lat = cyc - e.t;
          check("rx_data", 32'(data), 32'(e.b));
          check("latency_in_window", 32'((lat >= LAT_NOM - 3) && (lat <= LAT_NOM + 3)), 32'd1);
          data_model = e.b;
          n_valid++;
        end
      end
`ifdef UART_RX_FRAME_ERR_EN
      if (frame_err) begin
        n_fe_seen++;
        if (fe_pending == 0) begin
          check("unexp_frame_err", 32'(frame_err), 32'd0);
        end else begin
          fe_pending--;
          check("fe_data_hold", 32'(data), 32'(data_model));
        end
      end
`endif
      valid_prev = valid;
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       prev_stop;
    int         gap;

    // Reset with the line idle.
    rst = 1'b0;
    rx  = 1'b1;
    #100;
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    check("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("idle_no_valid", 32'(n_valid), 32'd0);

    // A short low glitch must be rejected at the mid-start-bit check.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_valid", 32'(n_valid), 32'd0);
    check("glitch_data", 32'(data), 32'h00);
`ifdef UART_RX_FRAME_ERR_EN
    check("glitch_no_fe", 32'(n_fe_seen), 32'd0);
`endif

    // A single frame.
    send_frame(8'hA5, 1'b1, -1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("a5_count", 32'(n_valid), 32'd1);
    check("a5_data", 32'(data), 32'hA5);

    // Two frames back to back, with no idle gap between them.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("b2b_count", 32'(n_valid), 32'd3);
    check("b2b_data", 32'(data), 32'hFF);

    // A framing error, with the line then held low (break).
    send_frame(8'h3C, 1'b0, -1);
    repeat (4 * CPB) @(negedge clk);
    check("ferr_count", 32'(n_valid), 32'd3);
    check("ferr_data_hold", 32'(data), 32'hFF);
`ifdef UART_RX_FRAME_ERR_EN
    check("ferr_pulses", 32'(n_fe_seen), 32'd1);
`endif
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h5A, 1'b1, 4);
    repeat (2 * CPB) @(negedge clk);
    check("abort_count", 32'(n_valid), 32'd3);
    check("abort_data", 32'(data), 32'h00);
    send_frame(8'h81, 1'b1, -1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("post_abort_count", 32'(n_valid), 32'd4);
    check("post_abort_data", 32'(data), 32'h81);

    // Random frames, with occasional bad stop bits and random idle gaps.
    prev_stop = 1'b1;
    for (int i = 0; i < 30; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gap  = prev_stop ? $urandom_range(0, CPB) : $urandom_range(2, CPB);
      rx   = 1'b1;
      repeat (gap) @(negedge clk);
      send_frame(b, stop, -1);
      prev_stop = stop;
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    check("queue_empty", 32'(expq.size()), 32'd0);
    check("valid_total", 32'(n_valid), 32'(n_good));
    check("data_final", 32'(data), 32'(data_model));
`ifdef UART_RX_FRAME_ERR_EN
    check("fe_pending", 32'(fe_pending), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Deserialises the rx line into a byte and presents it with a one-cycle valid strobe.
- Sits at the chip's UART input, feeding a byte-oriented consumer such as a FIFO or command parser.
- Timing is derived from a clock-cycle counter, not a separate baud clock.

Parameters:
- BAUD_RATE, 9600, serial bit rate in bits/s.
- CLOCK_FREQ, 38400000, clk frequency in Hz.
- Derived, not overridable:
  - CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division; default 4000.
  - HALF_BIT = CLKS_PER_BIT/2; default 2000.
  - CLKS_PER_BIT must be ≥ 4.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-low reset. rst=0 resets the block immediately; release is synchronous to clk.
- rx, input, 1, serial line, asynchronous to clk, idle high.
- data, output, 8, last correctly framed byte; holds its value between frames.
- valid, output, 1, one-clk pulse when data is updated.

Behaviour:
- Reset (rst=0):
  - state=IDLE; data=8'h00; valid=0.
  - Synchroniser flops and previous-sample register = 1 (line idle).
  - Bit counter and cycle counter = 0.
  - Reset asserted mid-frame aborts the frame; no valid is produced for it.
- Synchroniser: rx passes through a 2-flop synchroniser giving rx_s. All decisions use rx_s only.
- Cycle counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state transition and on every data-bit sample.
- IDLE:
  - Start detection is a falling edge: previous rx_s=1 and current rx_s=0 → START, counter=0.
  - A line held low, e.g. a break, never re-triggers a start.
- START:
  - Counts to HALF_BIT-1, then samples rx_s.
  - rx_s=0 → DATA with bit_idx=0.
  - rx_s=1 → glitch; return to IDLE with no output change.
- DATA:
  - Each time the counter reaches CLKS_PER_BIT-1, shift rx_s into shift-register bit [bit_idx] (LSB first) and increment bit_idx.
  - After bit 7 is sampled → STOP.
- STOP:
  - At counter = CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 → data<=shift register and valid<=1 for exactly one cycle.
  - rx_s=0 → framing error: data unchanged, valid stays 0.
  - Either outcome → IDLE.
- Latency: valid rises HALF_BIT+9*CLKS_PER_BIT cycles (±3 for synchronisation) after the rx falling edge. That is 38000 cycles, about 989.6 µs, at the defaults.
- Back-to-back frames: a new start edge is accepted from the first cycle in IDLE, which leaves half a stop bit of margin.
- valid is never high for 2 consecutive cycles.
- No interaction with any consumer: there is no ready/backpressure. The consumer must capture data on valid.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses high for one cycle when the stop-bit sample is 0.
  - The glitch rejection in START does not raise frame_err.
- Undefined: port absent; framing errors are silently dropped. All other behaviour is identical.

Test Plan:
- Reset with rst=0, rx=1 for 100 ns → data=00, valid=0. Release rst=1 and idle 1 ms → valid never asserted.
- Glitch: rx low for 200 ns (~8 clk) then high → START aborts at HALF_BIT; no valid, data stays 00; frame_err stays 0 if enabled.
- Frame 0xA5 at 9600 baud (104.167 µs/bit) → exactly one valid pulse ~989.6 µs after the start edge, with data=A5.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two valid pulses one frame apart; data=00 then FF.
- Frame 0x3C with stop bit driven 0 → no valid, data keeps its previous value. frame_err pulses once if UART_RX_FRAME_ERR_EN; the line held low afterwards produces no new frame until rx goes high then low.
- Assert rst=0 during data bit 4 of a frame, release, then send 0x81 → only 0x81 is reported, with one valid pulse.
